digit_serial_adder: RTL

Multi-cycle, parametrised successor to the single-bit full adder cell. It adds two WIDTH-bit operands DIGIT bits per clock, using a chain of DIGIT full-adder cells and a registered carry between digits. It accepts one operation through a valid/ready input handshake and returns Sum, carry-out and signed overflow through a valid/ready output handshake. It sits in the datapath wherever a wide add is needed and area matters more than latency.

---
 rtl/digit_serial_adder.sv | 117 +++++++++++
 1 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit add, DIGIT bits per clock, valid/ready in and out.
// Define SUB_MODE_EN to add the sub port (A - B as A + ~B + 1).
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             ca,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q, acc, acc_nx;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             carry_q;
  logic [IW-1:0]    idx;
  logic [DIGIT-1:0] da, db, ds;
  logic [DIGIT:0]   c;
  logic             last;

`ifdef SUB_MODE_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub | cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  assign last = (idx == LAST);

  // One digit of full-adder cells fed by the registered carry
  always_comb begin
    da = a_q[idx*DIGIT +: DIGIT];
    db = b_q[idx*DIGIT +: DIGIT];
    ds = '0;
    c = '0;
    c[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      ds[i]  = da[i] ^ db[i] ^ c[i];
      c[i+1] = (da[i] & db[i]) | (c[i] & (da[i] ^ db[i]));
    end
    acc_nx = acc;
    acc_nx[idx*DIGIT +: DIGIT] = ds;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)  state_nx = RUN;
      RUN:  if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      ca      <= 1'b0;
      ovf     <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q     <= a;
      b_q     <= b_load;
      carry_q <= c_load;
      idx     <= '0;
    end else if (state == RUN) begin
      acc     <= acc_nx;
      carry_q <= c[DIGIT];
      idx     <= idx + 1'b1;
      if (last) begin
        sum <= acc_nx;
        ca  <= c[DIGIT];
        ovf <= c[DIGIT] ^ c[DIGIT-1];
      end
    end
  end

endmodule
